// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register serial link: receiver FSM states,
// line levels of the frame and the power-counter width.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

    localparam int PWR_CNT_W = 16;

endpackage

// File: rtl/sr_rx_shifter.sv
// Bidirectional shift buffer of the serial receiver: collects data bits either
// LSB-first (entering at the MSB, shifting right) or MSB-first (entering at the LSB).
module sr_rx_shifter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_shiftEn,
    input  logic             i_clear,
    input  logic             i_dir,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_word
);

    logic [WIDTH-1:0] r_word;
    logic [WIDTH:0]   w_left;
    logic [WIDTH:0]   w_right;

    // Widened concatenations keep both shift directions valid even for WIDTH=1.
    assign w_left  = {r_word, i_bit};
    assign w_right = {i_bit, r_word};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_word <= '0;
        end else if (i_clear) begin
            r_word <= '0;
        end else if (i_shiftEn) begin
            r_word <= i_dir ? w_left[WIDTH-1:0] : w_right[WIDTH:1];
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/shift_reg_rx.sv
// Serial receiver for the shifting register: start, WIDTH data bits, even parity, stop.
// Optional VALID rising-edge counter on PWR_CNT when SHIFT_REG_RX_PWR_CNT_EN is defined.
module shift_reg_rx
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PwrC  = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENB,
    input  logic                 S_IN,
    input  logic                 DIR,
    input  logic                 ACK,
    output logic [WIDTH-1:0]     Q,
    output logic                 VALID,
    output logic                 PAR_ERR,
    output logic                 FRM_ERR,
    output logic                 OVR,
`ifdef SHIFT_REG_RX_PWR_CNT_EN
    output logic [PWR_CNT_W-1:0] PWR_CNT,
`endif
    output logic                 BUSY
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_perr;
    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic             r_parErr;
    logic             r_frmErr;
    logic             r_ovr;
    logic             w_shiftEn;
    logic             w_clear;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;
    logic [WIDTH-1:0] w_word;
    logic             w_unused_pwrc;

    // The slot index only matters to the bench that owns the power-counter array.
    assign w_unused_pwrc = (PwrC != 0);

    sr_rx_shifter #(.WIDTH(WIDTH)) u_shifter (
        .i_clk     (CLK),
        .i_reset   (RESET),
        .i_shiftEn (w_shiftEn),
        .i_clear   (w_clear),
        .i_dir     (r_dir),
        .i_bit     (S_IN),
        .o_word    (w_word)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Nothing advances without ENB, so a stalled frame simply stretches.
    always_comb begin
        w_next     = r_state;
        w_shiftEn  = 1'b0;
        w_clear    = 1'b0;
        w_complete = 1'b0;
        if (ENB) begin
            case (r_state)
                ST_IDLE: begin
                    if (S_IN == START_BIT) begin
                        w_next  = ST_DATA;
                        w_clear = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_shiftEn = 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        w_next = ST_PARITY;
                    end
                end
                ST_PARITY: w_next = ST_STOP;
                ST_STOP: begin
                    w_next     = ST_IDLE;
                    w_complete = 1'b1;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt  <= '0;
            r_dir  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (w_clear) begin
                r_cnt <= '0;
                r_dir <= DIR;
            end else if (w_shiftEn) begin
                r_cnt <= (r_cnt == LAST_BIT) ? '0 : r_cnt + 1'b1;
            end
            if (ENB && r_state == ST_PARITY) begin
                r_perr <= ^{w_word, S_IN};
            end
        end
    end

    // A completing frame wins over a plain ACK; a held unacked word forces a drop.
    assign w_load = w_complete && (!r_valid || ACK);
    assign w_drop = w_complete && r_valid && !ACK;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q      <= '0;
            r_valid  <= 1'b0;
            r_parErr <= 1'b0;
            r_frmErr <= 1'b0;
            r_ovr    <= 1'b0;
        end else if (ENB) begin
            if (w_load) begin
                r_q      <= w_word;
                r_parErr <= r_perr;
                r_frmErr <= (S_IN != STOP_BIT);
                r_valid  <= 1'b1;
            end else if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (ACK && r_valid) begin
                r_valid  <= 1'b0;
                r_parErr <= 1'b0;
                r_frmErr <= 1'b0;
                r_ovr    <= 1'b0;
            end
        end
    end

`ifdef SHIFT_REG_RX_PWR_CNT_EN
    logic [PWR_CNT_W-1:0] r_pwrCnt;

    // Counts VALID 0->1 transitions only; loading over a held word keeps VALID high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pwrCnt <= '0;
        end else if (ENB && w_load && !r_valid && r_pwrCnt != '1) begin
            r_pwrCnt <= r_pwrCnt + 1'b1;
        end
    end

    assign PWR_CNT = r_pwrCnt;
`endif

    assign Q       = r_q;
    assign VALID   = r_valid;
    assign PAR_ERR = r_parErr;
    assign FRM_ERR = r_frmErr;
    assign OVR     = r_ovr;
    assign BUSY    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shift_reg_rx.sv
// Bench for shift_reg_rx: directed frames with literal expectations, then random
// traffic checked every cycle against a frame-level model of the receiver.
module tb_shift_reg_rx;

    localparam int WIDTH = 4;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             ENB;
    logic             S_IN;
    logic             DIR;
    logic             ACK;
    logic [WIDTH-1:0] Q;
    logic             VALID;
    logic             PAR_ERR;
    logic             FRM_ERR;
    logic             OVR;
    logic             BUSY;
`ifdef SHIFT_REG_RX_PWR_CNT_EN
    logic [15:0]      PWR_CNT;
`endif

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    shift_reg_rx #(.WIDTH(WIDTH), .PwrC(0)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ENB     (ENB),
        .S_IN    (S_IN),
        .DIR     (DIR),
        .ACK     (ACK),
        .Q       (Q),
        .VALID   (VALID),
        .PAR_ERR (PAR_ERR),
        .FRM_ERR (FRM_ERR),
        .OVR     (OVR),
`ifdef SHIFT_REG_RX_PWR_CNT_EN
        .PWR_CNT (PWR_CNT),
`endif
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    // Frame-level model: collect the bits after the start bit, decode once a full frame is in.
    bit             mInFrame = 1'b0;
    bit             mDir     = 1'b0;
    bit             mBits[$];
    logic [WIDTH-1:0] mQ     = '0;
    bit             mValid   = 1'b0;
    bit             mPerr    = 1'b0;
    bit             mFerr    = 1'b0;
    bit             mOvr     = 1'b0;
    int             mPwr     = 0;
    bit             mDone;
    logic [WIDTH-1:0] mWord;
    bit             mPx;

    always @(posedge CLK) begin
        if (RESET) begin
            mInFrame = 1'b0;
            mBits.delete();
            mQ = '0; mValid = 1'b0; mPerr = 1'b0; mFerr = 1'b0; mOvr = 1'b0; mPwr = 0;
        end else if (ENB) begin
            mDone = 1'b0;
            if (!mInFrame) begin
                if (S_IN) begin
                    mInFrame = 1'b1;
                    mDir = DIR;
                    mBits.delete();
                end
            end else begin
                mBits.push_back(S_IN);
                if (mBits.size() == WIDTH + 2) begin
                    mDone = 1'b1;
                    mInFrame = 1'b0;
                end
            end
            if (mDone) begin
                if (!mValid || ACK) begin
                    mWord = '0;
                    mPx = 1'b0;
                    for (int i = 0; i < WIDTH; i++) mWord[mDir ? WIDTH - 1 - i : i] = mBits[i];
                    for (int i = 0; i <= WIDTH; i++) mPx ^= mBits[i];
                    if (!mValid && mPwr < 65535) mPwr++;
                    mQ = mWord; mPerr = mPx; mFerr = mBits[WIDTH + 1]; mValid = 1'b1;
                end else begin
                    mOvr = 1'b1;
                end
            end else if (ACK && mValid) begin
                mValid = 1'b0; mPerr = 1'b0; mFerr = 1'b0; mOvr = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (checkEn) begin
            checkOutput("model Q", 32'(Q), 32'(mQ));
            checkOutput("model VALID", 32'(VALID), 32'(mValid));
            checkOutput("model PAR_ERR", 32'(PAR_ERR), 32'(mPerr));
            checkOutput("model FRM_ERR", 32'(FRM_ERR), 32'(mFerr));
            checkOutput("model OVR", 32'(OVR), 32'(mOvr));
            checkOutput("model BUSY", 32'(BUSY), 32'(mInFrame));
`ifdef SHIFT_REG_RX_PWR_CNT_EN
            checkOutput("model PWR_CNT", 32'(PWR_CNT), 32'(mPwr));
`endif
        end
    end

    task automatic applyStimulus(input logic rst, input logic enb, input logic s,
                                 input logic dir, input logic ack);
        RESET = rst; ENB = enb; S_IN = s; DIR = dir; ACK = ack;
        @(posedge CLK);
        #2;
    endtask

    // d[0] is the first data bit on the line.
    task automatic sendFrame(input logic dirIn, input logic [3:0] d, input logic par,
                             input logic stp, input logic ackAtStop);
        applyStimulus(1'b0, 1'b1, 1'b1, dirIn, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, d[i], dirIn, 1'b0);
        applyStimulus(1'b0, 1'b1, par, dirIn, 1'b0);
        applyStimulus(1'b0, 1'b1, stp, dirIn, ackAtStop);
    endtask

    task automatic ackCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    logic [6:0] stream1;

    initial begin
        RESET = 1'b1; ENB = 1'b0; S_IN = 1'b0; DIR = 1'b0; ACK = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkEn = 1'b1;
        checkOutput("reset Q", 32'(Q), 0);
        checkOutput("reset VALID", 32'(VALID), 0);
        checkOutput("reset BUSY", 32'(BUSY), 0);
        checkOutput("reset OVR", 32'(OVR), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // LSB-first 1011 with good parity, stop 0: word D after seven edges
        stream1 = 7'b0111011;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, stream1[i], 1'b0, 1'b0);
            if (i == 0) checkOutput("busy after start", 32'(BUSY), 1);
            if (i == 5) checkOutput("valid not early", 32'(VALID), 0);
        end
        checkOutput("f1 VALID", 32'(VALID), 1);
        checkOutput("f1 Q", 32'(Q), 32'hD);
        checkOutput("f1 PAR_ERR", 32'(PAR_ERR), 0);
        checkOutput("f1 FRM_ERR", 32'(FRM_ERR), 0);
        checkOutput("f1 BUSY", 32'(BUSY), 0);
        ackCycle();
        checkOutput("f1 acked", 32'(VALID), 0);

        // MSB-first, same data bits, bad parity
        sendFrame(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0);
        checkOutput("f2 Q", 32'(Q), 32'hB);
        checkOutput("f2 PAR_ERR", 32'(PAR_ERR), 1);
        ackCycle();

        // Stop bit 1, then S_IN held high restarts immediately (ACK clears old word)
        sendFrame(1'b0, 4'b0010, 1'b1, 1'b1, 1'b0);
        checkOutput("f3 Q", 32'(Q), 32'h2);
        checkOutput("f3 FRM_ERR", 32'(FRM_ERR), 1);
        checkOutput("f3 VALID", 32'(VALID), 1);
        checkOutput("f3 PAR_ERR", 32'(PAR_ERR), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("f3 restart BUSY", 32'(BUSY), 1);
        checkOutput("f3 restart VALID", 32'(VALID), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("f3b Q", 32'(Q), 32'h3);
        checkOutput("f3b FRM_ERR", 32'(FRM_ERR), 0);
        ackCycle();

        // Back-to-back with no ACK: second frame dropped
        sendFrame(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
        sendFrame(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b Q", 32'(Q), 32'h3);
        checkOutput("b2b OVR", 32'(OVR), 1);
        checkOutput("b2b VALID", 32'(VALID), 1);
        ackCycle();
        checkOutput("b2b ack VALID", 32'(VALID), 0);
        checkOutput("b2b ack OVR", 32'(OVR), 0);

        // ACK on the stop edge of the second frame replaces the word
        sendFrame(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
        sendFrame(1'b0, 4'b0101, 1'b0, 1'b0, 1'b1);
        checkOutput("ackstop Q", 32'(Q), 32'h5);
        checkOutput("ackstop VALID", 32'(VALID), 1);
        checkOutput("ackstop OVR", 32'(OVR), 0);
        ackCycle();

        // ENB low for three cycles mid-data
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
        checkOutput("stall BUSY", 32'(BUSY), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("stall Q", 32'(Q), 32'h6);
        checkOutput("stall VALID", 32'(VALID), 1);
        ackCycle();

        // Reset mid-frame with a word pending
        sendFrame(1'b0, 4'b1001, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("midrst Q", 32'(Q), 0);
        checkOutput("midrst VALID", 32'(VALID), 0);
        checkOutput("midrst BUSY", 32'(BUSY), 0);
        checkOutput("midrst PAR_ERR", 32'(PAR_ERR), 0);
        checkOutput("midrst FRM_ERR", 32'(FRM_ERR), 0);
        checkOutput("midrst OVR", 32'(OVR), 0);
`ifdef SHIFT_REG_RX_PWR_CNT_EN
        checkOutput("midrst PWR_CNT", 32'(PWR_CNT), 0);
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sendFrame(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
        checkOutput("post-reset Q", 32'(Q), 32'h1);
        checkOutput("post-reset PAR_ERR", 32'(PAR_ERR), 0);
`ifdef SHIFT_REG_RX_PWR_CNT_EN
        checkOutput("post-reset PWR_CNT", 32'(PWR_CNT), 1);
`endif
        ackCycle();

        // Random traffic, DIR toggling freely to confirm it is latched at the start bit
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 249) == 0),
                          1'($urandom_range(0, 9) < 8),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
